// File: rtl/mux_select_pipe.sv
// rtl/mux_select_pipe.sv - selectable input mux with optional shift into a 2-entry skid buffer
module mux_select_pipe #(
    parameter int          WIDTH      = 32,
    parameter int          NUM_INPUTS = 4,
    parameter int          SEL_WIDTH  = 2,
    parameter logic [15:0] SHIFT_MASK = 16'h0002,
    parameter int          SHIFT_AMT  = 2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]        selector,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        sel_error,
    output logic [15:0]                 xfer_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] skid_data;
    logic [WIDTH-1:0] result;
    logic             bad_sel;
    logic             accept;
    logic             consume;
    logic [WIDTH-1:0] out_data_next;
    logic [WIDTH-1:0] skid_data_next;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;
    assign bad_sel = 32'(selector) >= 32'(NUM_INPUTS);

    // Select the addressed input and apply the per-input shift; out-of-range selectors yield zero
    always_comb begin
        result = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (selector == SEL_WIDTH'(i)) begin
                if (SHIFT_MASK[i]) begin
                    result = in_data[i*WIDTH +: WIDTH] >> SHIFT_AMT;
                end else begin
                    result = in_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Buffer occupancy transitions and the data each register loads on this edge
    always_comb begin
        state_next     = state;
        out_data_next  = out_data;
        skid_data_next = skid_data;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next    = ONE;
                    out_data_next = result;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    out_data_next = result;
                end else if (accept) begin
                    state_next     = FULL;
                    skid_data_next = result;
                end else if (consume) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the skid promotion can happen
                if (consume) begin
                    state_next    = ONE;
                    out_data_next = skid_data;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // State and data registers; ready/valid are registered so in_ready never depends on out_ready combinationally
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= EMPTY;
            out_data  <= '0;
            skid_data <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_next;
            out_data  <= out_data_next;
            skid_data <= skid_data_next;
            out_valid <= (state_next != EMPTY);
            in_ready  <= (state_next != FULL);
        end
    end

    // Sticky bad-selector flag and free-running transfer counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sel_error  <= 1'b0;
            xfer_count <= 16'h0000;
        end else begin
            if (accept && bad_sel) begin
                sel_error <= 1'b1;
            end
            if (consume) begin
                xfer_count <= xfer_count + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_mux_select_pipe.sv
// tb/tb_mux_select_pipe.sv - directed self-checking bench for mux_select_pipe
module tb_mux_select_pipe;

    localparam int WIDTH      = 32;
    localparam int NUM_INPUTS = 3;
    localparam int SEL_WIDTH  = 2;

    logic                        clock;
    logic                        reset_n;
    logic [NUM_INPUTS*WIDTH-1:0] in_data;
    logic [SEL_WIDTH-1:0]        selector;
    logic                        in_valid;
    logic                        in_ready;
    logic [WIDTH-1:0]            out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        sel_error;
    logic [15:0]                 xfer_count;

    int checks   = 0;
    int failures = 0;

    mux_select_pipe #(
        .WIDTH      (WIDTH),
        .NUM_INPUTS (NUM_INPUTS),
        .SEL_WIDTH  (SEL_WIDTH),
        .SHIFT_MASK (16'h0002),
        .SHIFT_AMT  (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .selector   (selector),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sel_error  (sel_error),
        .xfer_count (xfer_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input int idx, input logic [31:0] val);
        in_data[idx*WIDTH +: WIDTH] = val;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_data   = '0;
        selector  = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_in(0, 32'hDEAD_BEEF);
        set_in(1, 32'h0000_0100);
        set_in(2, 32'h1234_5678);
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_sel_error", 32'(sel_error), 32'd0);
        chk("rst_xfer", 32'(xfer_count), 32'd0);

        // Pass-through with shift on input 1, then unshifted input 0 in state ONE
        reset_n   = 1'b1;
        selector  = 2'd1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        chk("pt_shift_data", out_data, 32'h0000_0040);
        chk("pt_shift_valid", 32'(out_valid), 32'd1);
        chk("pt_xfer0", 32'(xfer_count), 32'd0);
        selector = 2'd0;
        step();
        chk("sim_data", out_data, 32'hDEAD_BEEF);
        chk("sim_valid", 32'(out_valid), 32'd1);
        chk("sim_in_ready", 32'(in_ready), 32'd1);
        chk("sim_xfer", 32'(xfer_count), 32'd1);
        in_valid = 1'b0;
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_xfer", 32'(xfer_count), 32'd2);

        // Unshifted input 2
        selector = 2'd2;
        in_valid = 1'b1;
        step();
        chk("in2_data", out_data, 32'h1234_5678);
        in_valid = 1'b0;
        step();
        chk("in2_xfer", 32'(xfer_count), 32'd3);

        // Backpressure: A and B accepted, C held until space frees
        out_ready = 1'b0;
        in_valid  = 1'b1;
        selector  = 2'd2;
        set_in(2, 32'h0000_000A);
        step();
        chk("bp_a_data", out_data, 32'h0000_000A);
        chk("bp_a_ready", 32'(in_ready), 32'd1);
        set_in(2, 32'h0000_000B);
        step();
        chk("bp_b_ready", 32'(in_ready), 32'd0);
        chk("bp_b_hold", out_data, 32'h0000_000A);
        set_in(2, 32'h0000_000C);
        step();
        chk("bp_c_ready", 32'(in_ready), 32'd0);
        chk("bp_c_hold", out_data, 32'h0000_000A);
        chk("bp_c_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        chk("bp_out_b", out_data, 32'h0000_000B);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        step();
        chk("bp_out_c", out_data, 32'h0000_000C);
        in_valid = 1'b0;
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_xfer", 32'(xfer_count), 32'd6);

        // Bad selector gives zero and a sticky error
        selector = 2'd3;
        in_valid = 1'b1;
        step();
        chk("bad_data", out_data, 32'd0);
        chk("bad_valid", 32'(out_valid), 32'd1);
        chk("bad_err", 32'(sel_error), 32'd1);
        selector = 2'd0;
        step();
        chk("bad_next_data", out_data, 32'hDEAD_BEEF);
        chk("bad_sticky", 32'(sel_error), 32'd1);
        in_valid = 1'b0;
        step();

        // Fill to FULL then reset mid-operation
        out_ready = 1'b0;
        in_valid  = 1'b1;
        selector  = 2'd1;
        step();
        step();
        chk("full_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b0;
        step();
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_ready", 32'(in_ready), 32'd1);
        chk("mrst_xfer", 32'(xfer_count), 32'd0);
        chk("mrst_err", 32'(sel_error), 32'd0);
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("mrst_no_ghost", 32'(out_valid), 32'd0);
        step();
        chk("mrst_no_ghost2", 32'(out_valid), 32'd0);

        // Counter wrap: stream one transfer per cycle
        in_valid = 1'b1;
        selector = 2'd0;
        for (int n = 0; n < 65536; n++) begin
            step();
        end
        chk("wrap_max", 32'(xfer_count), 32'h0000_FFFF);
        step();
        chk("wrap_zero", 32'(xfer_count), 32'd0);
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
